// File: rtl/stack_program_feeder_if.sv
// Load/replay interface for stack_program_feeder.
// The master side loads programs and consumes nibbles; the slave side is the feeder.
interface stack_program_feeder_if #(
  parameter int AW = 4
);
  logic          clear;
  logic          load;
  logic [3:0]    in_nibble;
  logic          start;
  logic          cpu_ready;
  logic [3:0]    out_nibble;
  logic          out_valid;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic          overflow;

  modport master (
    output clear, load, in_nibble, start, cpu_ready,
    input  out_nibble, out_valid, busy, done, count, overflow
  );

  modport slave (
    input  clear, load, in_nibble, start, cpu_ready,
    output out_nibble, out_valid, busy, done, count, overflow
  );
endinterface

// File: rtl/stack_program_feeder.sv
// Program buffer that replays stored nibbles into the stack_cpu input stream.
// Replay is valid/ready, with an optional loop-forever mode.
module stack_program_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter bit LOOP  = 1'b0
) (
  input logic clk,
  input logic rst,
  stack_program_feeder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [3:0]    mem_q [DEPTH];
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic          wr_en;
  logic          xfer;
  logic          last;

  assign xfer  = (state_q == RUN) && bus.cpu_ready;
  assign last  = ({1'b0, rd_ptr_q} == (count_q - 1'b1));
  assign wr_en = (state_q == IDLE) && bus.load &&
                 !bus.clear && (count_q != FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'h0;
    end else if (wr_en) begin
      mem_q[count_q[AW-1:0]] <= bus.in_nibble;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (bus.clear) begin
      state_d  = IDLE;
      count_d  = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.load) begin
            if (count_q == FULL) ovf_d = 1'b1;
            else count_d = count_q + 1'b1;
          end else if (bus.start && count_q != '0) begin
            state_d  = RUN;
            rd_ptr_d = '0;
          end
        end
        RUN: begin
          if (xfer) begin
            if (last) begin
              rd_ptr_d = '0;
              if (!LOOP) state_d = DONE;
            end else begin
              rd_ptr_d = rd_ptr_q + 1'b1;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.out_valid  = 1'b0;
    bus.out_nibble = 4'h0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    unique case (1'b1)
      (state_q == RUN): begin
        bus.out_valid  = 1'b1;
        bus.out_nibble = mem_q[rd_ptr_q];
        bus.busy       = 1'b1;
      end
      (state_q == DONE): begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
    bus.count    = count_q;
    bus.overflow = ovf_q;
  end
endmodule

// File: tb/tb_stack_program_feeder.sv
// Scoreboard bench for stack_program_feeder: one-shot and looping instances.
// Expected nibbles are queued by the stimulus and popped by negedge monitors.
module tb_stack_program_feeder;
  logic clk = 1'b0;
  logic rst;
  int   vec = 0;
  int   bad = 0;

  logic [3:0] q0 [$];
  logic [3:0] q1 [$];
  logic       stall0 = 1'b0;
  logic [3:0] held0  = 4'h0;

  stack_program_feeder_if #(.AW(4)) f0 ();
  stack_program_feeder_if #(.AW(4)) f1 ();

  stack_program_feeder #(.DEPTH(16), .AW(4), .LOOP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(f0)
  );
  stack_program_feeder #(.DEPTH(16), .AW(4), .LOOP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(f1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic [3:0] v);
    f0.load      = 1'b1;
    f0.in_nibble = v;
    cyc();
    f0.load      = 1'b0;
  endtask

  task automatic load1(input logic [3:0] v);
    f1.load      = 1'b1;
    f1.in_nibble = v;
    cyc();
    f1.load      = 1'b0;
  endtask

  task automatic clear0();
    f0.clear = 1'b1;
    cyc();
    f0.clear = 1'b0;
  endtask

  task automatic start0();
    f0.start = 1'b1;
    cyc();
    f0.start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      stall0 = 1'b0;
    end else begin
      if (stall0 && f0.out_valid) chk("dut0_hold", f0.out_nibble, held0);
      if (f0.out_valid && f0.cpu_ready) begin
        if (q0.size() == 0) begin
          vec++;
          bad++;
          $display("FAIL dut0_unexpected: got %0h, expected none", f0.out_nibble);
        end else begin
          chk("dut0_out", f0.out_nibble, q0.pop_front());
        end
      end
      stall0 = f0.out_valid && !f0.cpu_ready;
      held0  = f0.out_nibble;
    end
  end

  always @(negedge clk) begin
    if (rst && f1.out_valid && f1.cpu_ready) begin
      if (q1.size() == 0) begin
        vec++;
        bad++;
        $display("FAIL dut1_unexpected: got %0h, expected none", f1.out_nibble);
      end else begin
        chk("dut1_out", f1.out_nibble, q1.pop_front());
      end
    end
  end

  initial begin
    bit         pat [5];
    logic [3:0] v;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    rst = 1'b0;
    f0.clear = 0; f0.load = 0; f0.in_nibble = 0; f0.start = 0; f0.cpu_ready = 0;
    f1.clear = 0; f1.load = 0; f1.in_nibble = 0; f1.start = 0; f1.cpu_ready = 0;
    #2;
    chk("rst_count", f0.count, 0);
    chk("rst_valid", f0.out_valid, 0);
    chk("rst_ovf", f0.overflow, 0);
    chk("rst_busy", f0.busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // basic 3-nibble program, always ready
    load0(4'h3); load0(4'h5); load0(4'hA);
    chk("t1_count", f0.count, 3);
    q0.push_back(4'h3); q0.push_back(4'h5); q0.push_back(4'hA);
    start0();
    chk("t1_valid", f0.out_valid, 1);
    chk("t1_busy", f0.busy, 1);
    f0.cpu_ready = 1'b1;
    repeat (3) cyc();
    chk("t1_done", f0.done, 1);
    chk("t1_done_busy", f0.busy, 1);
    chk("t1_done_valid", f0.out_valid, 0);
    cyc();
    chk("t1_idle_busy", f0.busy, 0);
    chk("t1_idle_done", f0.done, 0);
    f0.cpu_ready = 1'b0;

    // same program replayed with stalls
    q0.push_back(4'h3); q0.push_back(4'h5); q0.push_back(4'hA);
    start0();
    foreach (pat[i]) begin
      f0.cpu_ready = pat[i];
      cyc();
    end
    chk("t2_done", f0.done, 1);
    f0.cpu_ready = 1'b0;
    cyc();
    chk("t2_count", f0.count, 3);

    // fill to capacity and overflow
    clear0();
    chk("t3_clr_count", f0.count, 0);
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      load0(v);
    end
    chk("t3_full_count", f0.count, 16);
    chk("t3_full_ovf", f0.overflow, 0);
    load0(4'h1);
    chk("t3_ovf_count", f0.count, 16);
    chk("t3_ovf", f0.overflow, 1);
    for (int i = 0; i < 16; i++) q0.push_back(4'(i));
    start0();
    f0.cpu_ready = 1'b1;
    repeat (16) cyc();
    chk("t3_done", f0.done, 1);
    f0.cpu_ready = 1'b0;
    cyc();
    chk("t3_ovf_sticky", f0.overflow, 1);
    clear0();
    chk("t3_clear_count", f0.count, 0);
    chk("t3_clear_ovf", f0.overflow, 0);

    // looping instance
    load1(4'h7); load1(4'h9);
    for (int i = 0; i < 3; i++) begin
      q1.push_back(4'h7);
      q1.push_back(4'h9);
    end
    f1.start = 1'b1;
    cyc();
    f1.start = 1'b0;
    f1.cpu_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t4_no_done", f1.done, 0);
    end
    f1.cpu_ready = 1'b0;
    f1.clear = 1'b1;
    cyc();
    f1.clear = 1'b0;
    chk("t4_clear_valid", f1.out_valid, 0);
    chk("t4_clear_count", f1.count, 0);

    // start on empty buffer, then load+start together
    start0();
    chk("t5_empty_valid", f0.out_valid, 0);
    chk("t5_empty_busy", f0.busy, 0);
    f0.start = 1'b1;
    load0(4'h4);
    f0.start = 1'b0;
    chk("t5_ls_count", f0.count, 1);
    chk("t5_ls_busy", f0.busy, 0);
    q0.push_back(4'h4);
    start0();
    chk("t5_run_valid", f0.out_valid, 1);
    f0.cpu_ready = 1'b1;
    cyc();
    chk("t5_done", f0.done, 1);
    f0.cpu_ready = 1'b0;
    cyc();

    // async reset in the middle of a replay
    clear0();
    load0(4'h1); load0(4'h2); load0(4'h3); load0(4'h4);
    q0.push_back(4'h1); q0.push_back(4'h2);
    start0();
    f0.cpu_ready = 1'b1;
    cyc(); cyc();
    f0.cpu_ready = 1'b0;
    chk("t6_mid_valid", f0.out_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_valid", f0.out_valid, 0);
    chk("t6_rst_count", f0.count, 0);
    chk("t6_rst_done", f0.done, 0);
    chk("t6_rst_busy", f0.busy, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_rst_no_done", f0.done, 0);
    rst = 1'b1;
    cyc();
    chk("t6_after_done", f0.done, 0);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/stack_program_feeder.md
Name: stack_program_feeder

Overview:
- Upstream stage of stack_cpu: buffers a short program of 4-bit instruction/data nibbles, then replays them into the CPU's 4-bit input stream.
- Replay uses a valid/ready handshake, so the CPU (or bench) can stall.
- Allows a program to be loaded once and run repeatedly without re-driving the pins every cycle.

Parameters:
- DEPTH, 16, number of nibble slots in the program buffer (power of two, 2..16).
- AW, 4, pointer width, equals log2(DEPTH).
- LOOP, 0, 1 = restart at slot 0 after the last nibble instead of finishing.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush: empty buffer, return to IDLE.
- load  input  1  write in_nibble into next free slot (IDLE only).
- in_nibble  input  4  nibble to store.
- start  input  1  begin replay (IDLE only).
- cpu_ready  input  1  consumer accepts out_nibble this cycle.
- out_nibble  output  4  current nibble presented to the CPU.
- out_valid  output  1  out_nibble is valid.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse after last nibble accepted (LOOP=0).
- count  output  AW+1  number of nibbles stored, 0..DEPTH.
- overflow  output  1  sticky: a load was attempted while full.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; count=0; rd_ptr=0; overflow=0; done=0; out_valid=0; out_nibble=0.
  - All buffer slots = 0.
  - Reset mid-RUN aborts immediately; no done pulse.
- States: IDLE, RUN, DONE. All state, counters and flags are registered.
- IDLE:
  - load=1, count<DEPTH: mem[count[AW-1:0]]<=in_nibble; count<=count+1.
  - load=1, count==DEPTH: write dropped, count unchanged, overflow<=1.
  - start=1, load=0, count>0: next state RUN, rd_ptr<=0.
  - start=1 with count==0: ignored, stay IDLE.
  - load and start in the same cycle: load performed, start ignored.
  - out_valid=0, out_nibble=0, busy=0.
- RUN:
  - out_valid=1; out_nibble=mem[rd_ptr]; busy=1. The first nibble is visible the cycle after start is sampled.
  - Transfer = out_valid & cpu_ready, sampled on the rising edge.
  - No transfer: out_nibble and rd_ptr hold.
  - Transfer with rd_ptr<count-1: rd_ptr<=rd_ptr+1.
  - Transfer with rd_ptr==count-1, LOOP=1: rd_ptr<=0, stay RUN (wrap-around).
  - Transfer with rd_ptr==count-1, LOOP=0: next state DONE, rd_ptr<=0.
  - load and start ignored; buffer is read-only in RUN.
- DONE:
  - done=1 for exactly one cycle; out_valid=0; busy=1.
  - Next state IDLE unconditionally.
  - count and buffer contents are preserved, so a new start replays the same program and further loads append.
- clear=1 (any state):
  - Next state IDLE; count<=0; rd_ptr<=0; overflow<=0; done<=0.
  - Buffer contents need not be zeroed.
  - clear has priority over load, start and transfer in the same cycle.
- Widths:
  - count saturates at DEPTH.
  - rd_ptr is AW bits and never exceeds count-1.
- overflow clears only on rst or clear.

Test Plan:
- Load 0x3,0x5,0xA (3 cycles), then start, cpu_ready=1 → count=3; out_nibble 3,5,A on consecutive cycles with out_valid=1; done pulses one cycle after A is accepted; busy low the cycle after that.
- Same program with cpu_ready toggled 1,0,0,1,1 → each nibble held stable while out_valid=1 and cpu_ready=0; order 3,5,A preserved; no nibble skipped or duplicated.
- Load 17 nibbles 0x0..0xF then 0x1 with DEPTH=16 → count=16, overflow=1 after the 17th load; replay outputs 0x0..0xF; clear → count=0, overflow=0.
- LOOP=1, program 0x7,0x9, cpu_ready=1 for 6 cycles → output 7,9,7,9,7,9; done never asserted; clear → out_valid=0 next cycle.
- start with count=0 → stays IDLE, out_valid=0; load and start asserted together with count=0 → count=1, still IDLE; start next cycle → RUN.
- rst pulled low during RUN after the 2nd transfer → out_valid=0, count=0, done=0 immediately (asynchronous), with no done pulse.
